q_loop_sequencer: RTL and testbench
===================================

# q_loop_sequencer

Sequences the charge-regulation loop: triggers `q_measurement` cycles, waits for each result, and pulses the bisection controller's `enable` only when a fresh measurement is valid and out of tolerance. It also tracks the iteration budget, measurement timeouts and settle time after each `i_ref` update. It freezes the loop when `instability_detect` reports `setup_completed`. It sits in `top` between the measurement, control and instability blocks and drives their `start`/`enable` pins.

## Interface
- `BUS_WIDTH`, 10: width of charge buses.
- `TOL`, 1: lock tolerance, |q_desired − q_measured| ≤ TOL.
- `MAX_ITER`, 16: control updates allowed before fault.
- `SETTLE_CYCLES`, 8: wait after each `ctrl_enable` before the next measurement (≥1).
- `MEAS_TIMEOUT`, 1023: max cycles in WAIT_READY.
- `REMEASURE_PERIOD`, 4096: cycles between monitor measurements while LOCKED.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; loop active while high.
- `q_desired`  in  BUS_WIDTH  target charge, sampled every CHECK.
- `meas_ready`  in  1  `ready` from q_measurement (level).
- `q_measured`  in  BUS_WIDTH  result from q_measurement.
- `setup_completed`  in  1  from instability_detect.
- `meas_start`  out  1  one-cycle pulse to q_measurement `start`.
- `ctrl_enable`  out  1  one-cycle pulse to bisection `enable`.
- `busy`  out  1  high in any state except IDLE, LOCKED, FROZEN, FAULT.
- `locked`  out  1  high in LOCKED.
- `frozen`  out  1  high in FROZEN.
- `fault`  out  1  high in FAULT.
- `fault_code`  out  2  0 none, 1 measurement timeout, 2 iteration budget exhausted.
- `iter_count`  out  $clog2(MAX_ITER+1)  control updates issued since loop start.
- `q_last`  out  BUS_WIDTH  last accepted measurement.

## Operation
- States: IDLE, SETTLE, MEASURE, WAIT_READY, CHECK, UPDATE, LOCKED, FROZEN, FAULT.
- IDLE: on `run`=1, clear `iter_count`, go to MEASURE.
- MEASURE: drive `meas_start`=1 for this cycle only, go to WAIT_READY, clear the timer.
- WAIT_READY: accept only a rising edge of `meas_ready`, detected from a registered copy of it. A ready level already high on entry is stale and is ignored. On acceptance, latch `q_last`←`q_measured` and go to CHECK. If the timer reaches MEAS_TIMEOUT, go to FAULT with code 1.
- CHECK: compute diff = |q_desired − q_last| at BUS_WIDTH+1 signed width with no wrap.
  - diff ≤ TOL: go to LOCKED.
  - else if `iter_count`=MAX_ITER: go to FAULT with code 2.
  - else: go to UPDATE.
- UPDATE: drive `ctrl_enable`=1 for one cycle, increment `iter_count` (saturating), go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then go to MEASURE.
- LOCKED: count REMEASURE_PERIOD, then go to MEASURE without clearing `iter_count`. A CHECK that fails from a monitor measurement first clears `iter_count`, then proceeds to UPDATE.
- FROZEN: no pulses; `q_last` is held.
- FAULT: sticky; `fault_code` is held.
- Precedence, evaluated every cycle in every state except IDLE:
  1. `run`=0: go to IDLE. This overrides everything. Any in-flight measurement is abandoned and its late ready is ignored.
  2. `setup_completed`=1: go to FROZEN. This overrides timeout, CHECK and UPDATE; no `ctrl_enable` is issued in that cycle.
- FROZEN and FAULT exit only through `run`=0 or `rst`.

## Timing
- Reset values: state IDLE, all pulses 0, `busy`/`locked`/`frozen`/`fault` 0, `fault_code` 0, `iter_count` 0, `q_last` 0, timer 0, registered ready 0.
- All outputs are registered and decoded from state; there is no combinational input→output path.
- `run` rising at edge n: `meas_start` is high during cycle n+1.
- A `meas_ready` rise sampled at edge m (in WAIT_READY): `q_last` is updated at m+1, CHECK occurs in cycle m+1, and `ctrl_enable` is high in cycle m+2 when out of tolerance.
- Control period = 1 (MEASURE) + measurement latency + 1 (CHECK) + 1 (UPDATE) + SETTLE_CYCLES.
- `meas_start` and `ctrl_enable` are never high in the same cycle and are never high on consecutive cycles.
- Timeout: FAULT is entered on the edge at which the timer equals MEAS_TIMEOUT, i.e. MEAS_TIMEOUT+1 cycles after entering WAIT_READY.

## Structure
- Package `q_seq_pkg`: the state enum, the `fault_code` localparams (`FC_NONE`, `FC_TIMEOUT`, `FC_ITER`), and a function computing the abs-diff width.
- Sub-module `cycle_timer`: a single clear/count/terminal-count counter, shared by the SETTLE, WAIT_READY and LOCKED states. Its width is $clog2 of the maximum of the three parameters, plus 1.

## Test plan
- `q_desired`=300, measurement model returns 300 → a single `meas_start`, LOCKED after the first CHECK, `ctrl_enable` never pulses, `iter_count`=0.
- Model returns 200, 250, 280, 299 → 3 `ctrl_enable` pulses, each 1+SETTLE_CYCLES cycles before the next `meas_start`, then LOCKED with `iter_count`=3 and `q_last`=299.
- `meas_ready` held low → FAULT and `fault_code`=1 exactly MEAS_TIMEOUT+1 cycles after entering WAIT_READY; deasserting `run` returns to IDLE with `fault_code`=0.
- Model always returns 0 with MAX_ITER=4 → 4 `ctrl_enable` pulses, 5th CHECK enters FAULT with code 2.
- `setup_completed` raised in the same cycle as an out-of-tolerance CHECK → FROZEN next cycle, no `ctrl_enable`; `run` dropped mid-WAIT_READY and a late `meas_ready` → stays IDLE.
- `meas_ready` already high when WAIT_READY is entered → not accepted until it falls and rises again; while LOCKED, a monitor measurement of 310 against a target of 300 → `iter_count` cleared, `ctrl_enable` pulses.

Source files
------------

// File: rtl/q_loop_sequencer_pkg.sv
// Shared types and helpers for the charge-regulation loop sequencer.
// State encoding, fault codes and width helpers.
package q_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_WAIT,
    S_CHECK,
    S_UPDATE,
    S_LOCKED,
    S_FROZEN,
    S_FAULT
  } state_e;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_ITER    = 2'd2;

  // One extra bit keeps the signed difference from wrapping.
  function automatic int diff_w(input int bw);
    return bw + 1;
  endfunction

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/q_loop_sequencer_if.sv
// Bundle between the loop sequencer and its measurement,
// control and instability neighbours.
interface q_loop_sequencer_if #(
  parameter int BUS_WIDTH = 10,
  parameter int IW        = 5
);

  logic                 run;
  logic [BUS_WIDTH-1:0] q_desired;
  logic                 meas_ready;
  logic [BUS_WIDTH-1:0] q_measured;
  logic                 setup_completed;

  logic                 meas_start;
  logic                 ctrl_enable;
  logic                 busy;
  logic                 locked;
  logic                 frozen;
  logic                 fault;
  logic [1:0]           fault_code;
  logic [IW-1:0]        iter_count;
  logic [BUS_WIDTH-1:0] q_last;

  modport master (
    output run,
    output q_desired,
    output meas_ready,
    output q_measured,
    output setup_completed,
    input  meas_start,
    input  ctrl_enable,
    input  busy,
    input  locked,
    input  frozen,
    input  fault,
    input  fault_code,
    input  iter_count,
    input  q_last
  );

  modport slave (
    input  run,
    input  q_desired,
    input  meas_ready,
    input  q_measured,
    input  setup_completed,
    output meas_start,
    output ctrl_enable,
    output busy,
    output locked,
    output frozen,
    output fault,
    output fault_code,
    output iter_count,
    output q_last
  );

endinterface

// File: rtl/q_loop_sequencer_cycle_timer.sv
// Clear/count/terminal-count counter shared by the
// settle, measurement-wait and lock-monitor states.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic [W-1:0] lim_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o = (cnt_q == lim_i);

  // Parks at the limit so idle states never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!tc_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/q_loop_sequencer.sv
// Charge-regulation loop sequencer: measure, check, update,
// settle; with lock monitoring, freeze and fault handling.
module q_loop_sequencer
  import q_seq_pkg::*;
#(
  parameter int BUS_WIDTH        = 10,
  parameter int TOL              = 1,
  parameter int MAX_ITER         = 16,
  parameter int SETTLE_CYCLES    = 8,
  parameter int MEAS_TIMEOUT     = 1023,
  parameter int REMEASURE_PERIOD = 4096
) (
  input logic          clk,
  input logic          rst,
  q_loop_sequencer_if.slave bus
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int DW = diff_w(BUS_WIDTH);
  localparam int TW = $clog2(max3(SETTLE_CYCLES,
    MEAS_TIMEOUT, REMEASURE_PERIOD)) + 1;

  localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);
  localparam logic [DW-1:0] TOL_V    = DW'(TOL);
  localparam logic [TW-1:0] L_TO     = TW'(MEAS_TIMEOUT);
  localparam logic [TW-1:0] L_ST     = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] L_RP     = TW'(REMEASURE_PERIOD - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         iter_q, iter_d;
  logic [BUS_WIDTH-1:0]  q_last_q, q_last_d;
  logic [1:0]            fc_q, fc_d;
  logic                  mon_q, mon_d;
  logic                  rdy_q;

  logic                  start_q;
  logic                  en_q;
  logic                  busy_q;
  logic                  lock_q;
  logic                  frz_q;
  logic                  flt_q;

  logic                  tmr_clr;
  logic [TW-1:0]         tmr_lim;
  logic                  tmr_tc;

  logic signed [DW-1:0]  delta;
  logic [DW-1:0]         diff;
  logic                  in_tol;
  logic                  rise;

  assign delta  = $signed({1'b0, bus.q_desired})
                - $signed({1'b0, q_last_q});
  assign diff   = delta[DW-1] ? $unsigned(-delta)
                              : $unsigned(delta);
  assign in_tol = (diff <= TOL_V);
  assign rise   = bus.meas_ready & ~rdy_q;

  always_comb begin
    tmr_lim = '1;
    unique case (1'b1)
      (state_q == S_WAIT):   tmr_lim = L_TO;
      (state_q == S_SETTLE): tmr_lim = L_ST;
      (state_q == S_LOCKED): tmr_lim = L_RP;
      default:               tmr_lim = '1;
    endcase
  end

  // Every state entry restarts the shared timer.
  assign tmr_clr = (state_d != state_q);

  cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .lim_i (tmr_lim),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    q_last_d = q_last_q;
    fc_d     = fc_q;
    mon_d    = mon_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          iter_d  = '0;
          mon_d   = 1'b0;
          fc_d    = FC_NONE;
          state_d = S_MEASURE;
        end
      end
      S_SETTLE: begin
        if (tmr_tc) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rise) begin
          q_last_d = bus.q_measured;
          state_d  = S_CHECK;
        end else if (tmr_tc) begin
          fc_d    = FC_TIMEOUT;
          state_d = S_FAULT;
        end
      end
      S_CHECK: begin
        mon_d = 1'b0;
        if (in_tol) begin
          state_d = S_LOCKED;
        end else if (mon_q) begin
          iter_d  = '0;
          state_d = S_UPDATE;
        end else if (iter_q == ITER_MAX) begin
          fc_d    = FC_ITER;
          state_d = S_FAULT;
        end else begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (iter_q != ITER_MAX) iter_d = iter_q + IW'(1);
        state_d = S_SETTLE;
      end
      S_LOCKED: begin
        if (tmr_tc) begin
          mon_d   = 1'b1;
          state_d = S_MEASURE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // Stop beats freeze; both cancel this cycle's work.
    if (state_q != S_IDLE) begin
      if (!bus.run) begin
        state_d  = S_IDLE;
        iter_d   = iter_q;
        q_last_d = q_last_q;
        fc_d     = FC_NONE;
        mon_d    = 1'b0;
      end else if (bus.setup_completed &&
                   state_q != S_FAULT) begin
        state_d  = S_FROZEN;
        iter_d   = iter_q;
        q_last_d = q_last_q;
        fc_d     = fc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      iter_q   <= '0;
      q_last_q <= '0;
      fc_q     <= FC_NONE;
      mon_q    <= 1'b0;
      rdy_q    <= 1'b0;
      start_q  <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      lock_q   <= 1'b0;
      frz_q    <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      q_last_q <= q_last_d;
      fc_q     <= fc_d;
      mon_q    <= mon_d;
      rdy_q    <= bus.meas_ready;
      start_q  <= (state_d == S_MEASURE);
      en_q     <= (state_d == S_UPDATE);
      busy_q   <= state_d inside {S_SETTLE, S_MEASURE,
                    S_WAIT, S_CHECK, S_UPDATE};
      lock_q   <= (state_d == S_LOCKED);
      frz_q    <= (state_d == S_FROZEN);
      flt_q    <= (state_d == S_FAULT);
    end
  end

  assign bus.meas_start  = start_q;
  assign bus.ctrl_enable = en_q;
  assign bus.busy        = busy_q;
  assign bus.locked      = lock_q;
  assign bus.frozen      = frz_q;
  assign bus.fault       = flt_q;
  assign bus.fault_code  = fc_q;
  assign bus.iter_count  = iter_q;
  assign bus.q_last      = q_last_q;

endmodule

// File: tb/tb_q_loop_sequencer.sv
// Bench for q_loop_sequencer: randomized measurement responder
// against a sequence-level model of the control loop.
module tb_q_loop_sequencer;

  localparam int BW   = 10;
  localparam int TOL  = 1;
  localparam int MAXI = 4;
  localparam int SC   = 8;
  localparam int MT   = 1023;
  localparam int RP   = 200;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  q_loop_sequencer_if #(
    .BUS_WIDTH (BW),
    .IW        ($clog2(MAXI + 1))
  ) bus ();

  q_loop_sequencer #(
    .BUS_WIDTH        (BW),
    .TOL              (TOL),
    .MAX_ITER         (MAXI),
    .SETTLE_CYCLES    (SC),
    .MEAS_TIMEOUT     (MT),
    .REMEASURE_PERIOD (RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int starts, ctrls, viol;
  int last_ctrl, rise_cyc, first_start;
  int lock_cyc, iter_at_ctrl, run_cyc;
  bit gap_pend, prev_start, prev_ctrl, prev_locked;

  logic [BW-1:0] rq[$];
  bit silent;
  int rwait, lmin, lmax;

  task automatic chk(input string tag, input int got,
                     input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.meas_start && bus.ctrl_enable) viol++;
    if ((bus.meas_start || bus.ctrl_enable) &&
        (prev_start || prev_ctrl)) viol++;
    prev_start = bus.meas_start;
    prev_ctrl  = bus.ctrl_enable;
    if (bus.meas_start) begin
      starts++;
      if (first_start < 0) first_start = cyc;
      if (gap_pend) begin
        chk("settle_gap", cyc - last_ctrl, 1 + SC);
        gap_pend = 0;
      end
    end
    if (bus.ctrl_enable) begin
      ctrls++;
      last_ctrl    = cyc;
      gap_pend     = 1;
      iter_at_ctrl = bus.iter_count;
      chk("ctrl_lat", cyc - rise_cyc, 2);
    end
    if (bus.locked && !prev_locked) lock_cyc = cyc;
    prev_locked = bus.locked;
    if (!silent) begin
      if (bus.meas_start) begin
        bus.meas_ready = 1'b0;
        rwait = $urandom_range(lmax, lmin);
      end else if (rwait > 0) begin
        rwait--;
        if (rwait == 0) begin
          bus.q_measured = (rq.size() > 0) ? rq.pop_front() : '0;
          bus.meas_ready = 1'b1;
          rise_cyc = cyc;
        end
      end
    end
  endtask

  task automatic restart();
    bus.run = 1'b0;
    bus.setup_completed = 1'b0;
    repeat (3) tick();
    starts = 0;
    ctrls = 0;
    first_start = -1;
    gap_pend = 0;
    rwait = 0;
    rise_cyc = -1;
    lock_cyc = -1;
    rq.delete();
  endtask

  task automatic go(input int tgt);
    bus.q_desired = BW'(tgt);
    bus.run = 1'b1;
    run_cyc = cyc;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(bus.locked || bus.fault || bus.frozen) &&
           n < budget) begin
      tick();
      n++;
    end
    chk("wait_budget",
        int'(bus.locked || bus.fault || bus.frozen), 1);
  endtask

  task automatic run_trial(input string nm, input int tgt,
                           input int v[$]);
    int k = -1;
    int e_lock, e_fc, e_n, e_q;
    restart();
    foreach (v[i]) rq.push_back(BW'(v[i]));
    for (int i = 0; i < v.size() && i <= MAXI; i++) begin
      if (k < 0 && absd(tgt, v[i]) <= TOL) k = i;
    end
    if (k >= 0) begin
      e_lock = 1; e_fc = 0; e_n = k; e_q = v[k];
    end else begin
      e_lock = 0; e_fc = 2; e_n = MAXI; e_q = v[MAXI];
    end
    go(tgt);
    wait_end(3000);
    chk({nm, ".lock"}, bus.locked, e_lock);
    chk({nm, ".fault"}, bus.fault, 1 - e_lock);
    chk({nm, ".code"}, bus.fault_code, e_fc);
    chk({nm, ".ctrls"}, ctrls, e_n);
    chk({nm, ".starts"}, starts, e_n + 1);
    chk({nm, ".iter"}, bus.iter_count, e_n);
    chk({nm, ".qlast"}, bus.q_last, e_q);
    chk({nm, ".startlat"}, first_start - run_cyc, 1);
  endtask

  initial begin
    int v[$];
    int tgt, k, x, n, lc;
    rst = 1'b1;
    bus.run = 1'b0;
    bus.q_desired = '0;
    bus.meas_ready = 1'b0;
    bus.q_measured = '0;
    bus.setup_completed = 1'b0;
    silent = 0;
    lmin = 1;
    lmax = 6;
    rwait = 0;
    rise_cyc = -1;
    first_start = -1;
    lock_cyc = -1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst.busy", bus.busy, 0);
    chk("rst.locked", bus.locked, 0);
    chk("rst.frozen", bus.frozen, 0);
    chk("rst.fault", bus.fault, 0);
    chk("rst.code", bus.fault_code, 0);
    chk("rst.iter", bus.iter_count, 0);
    chk("rst.qlast", bus.q_last, 0);
    chk("rst.pulses", bus.meas_start | bus.ctrl_enable, 0);

    run_trial("exact", 300, '{300});
    run_trial("seq", 300, '{200, 250, 280, 299});
    run_trial("tol_edge", 300, '{302, 301});
    run_trial("nowrap_lo", 0, '{1023, 0});
    run_trial("nowrap_hi", 1023, '{0, 1022});
    run_trial("iterfault", 300, '{0, 0, 0, 0, 0});

    for (int t = 0; t < 10; t++) begin
      v.delete();
      tgt = $urandom_range(1023, 0);
      k = $urandom_range(MAXI + 1, 0);
      for (int i = 0; i < k; i++) begin
        do x = $urandom_range(1023, 0);
        while (absd(tgt, x) <= TOL);
        v.push_back(x);
      end
      if (k <= MAXI) begin
        x = tgt + $urandom_range(2 * TOL, 0) - TOL;
        if (x < 0) x = 0;
        if (x > 1023) x = 1023;
        v.push_back(x);
      end
      run_trial($sformatf("rnd%0d", t), tgt, v);
    end

    // Measurement never answers.
    restart();
    silent = 1;
    bus.meas_ready = 1'b0;
    go(300);
    n = 0;
    while (!bus.fault && n < MT + 50) begin
      tick();
      n++;
    end
    chk("to.seen", bus.fault, 1);
    chk("to.lat", cyc - first_start, MT + 2);
    chk("to.code", bus.fault_code, 1);
    bus.run = 1'b0;
    tick();
    chk("to.clr_fault", bus.fault, 0);
    chk("to.clr_code", bus.fault_code, 0);
    chk("to.idle", bus.busy, 0);
    silent = 0;

    // Freeze raised during an out-of-tolerance check.
    restart();
    lmin = 3;
    lmax = 3;
    rq.push_back(100);
    rq.push_back(100);
    go(300);
    n = 0;
    while (rise_cyc < 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    bus.setup_completed = 1'b1;
    tick();
    chk("frz.frozen", bus.frozen, 1);
    chk("frz.no_en", bus.ctrl_enable, 0);
    repeat (10) tick();
    chk("frz.ctrls", ctrls, 0);
    chk("frz.starts", starts, 1);
    chk("frz.qlast", bus.q_last, 100);

    // Stop mid-wait; the late answer must be ignored.
    restart();
    chk("frz.exit", bus.frozen, 0);
    lmin = 10;
    lmax = 10;
    rq.push_back(111);
    go(500);
    n = 0;
    while (starts < 1 && n < 20) begin
      tick();
      n++;
    end
    repeat (3) tick();
    bus.run = 1'b0;
    repeat (15) tick();
    chk("late.busy", bus.busy, 0);
    chk("late.locked", bus.locked, 0);
    chk("late.qlast", bus.q_last, 100);
    chk("late.starts", starts, 1);

    // Ready already high when the wait begins.
    restart();
    silent = 1;
    bus.meas_ready = 1'b1;
    bus.q_measured = 777;
    go(300);
    repeat (8) tick();
    chk("stale.busy", bus.busy, 1);
    chk("stale.qlast", bus.q_last, 100);
    bus.meas_ready = 1'b0;
    tick();
    tick();
    bus.q_measured = 300;
    bus.meas_ready = 1'b1;
    rise_cyc = cyc;
    tick();
    tick();
    chk("stale.locked", bus.locked, 1);
    chk("stale.qlast2", bus.q_last, 300);
    silent = 0;

    // Lock monitor re-measures and finds drift.
    restart();
    lmin = 1;
    lmax = 6;
    rq.push_back(200);
    rq.push_back(300);
    go(300);
    wait_end(500);
    chk("mon.lock1", bus.locked, 1);
    chk("mon.iter1", bus.iter_count, 1);
    rq.push_back(310);
    rq.push_back(300);
    n = 0;
    while (starts < 3 && n < RP + 20) begin
      tick();
      n++;
    end
    chk("mon.gap", cyc - lock_cyc, RP);
    lc = lock_cyc;
    n = 0;
    while (ctrls < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("mon.ctrls", ctrls, 2);
    chk("mon.iter_clr", iter_at_ctrl, 0);
    n = 0;
    while (lock_cyc == lc && n < 100) begin
      tick();
      n++;
    end
    chk("mon.lock2", bus.locked, 1);
    chk("mon.iter2", bus.iter_count, 1);
    chk("mon.qlast", bus.q_last, 300);

    bus.run = 1'b0;
    tick();
    chk("pulse_rules", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
